// File: rtl/vga_timing_rx_if.sv
`timescale 1ns/1ps
// Video timing bundle between a sync source and the timing receiver.
// The master drives the sync pair and reads the rebuilt position; the
// slave is the receiver itself.
interface vga_timing_rx_if;
    logic       hsync;
    logic       vsync;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       valid;
    logic       locked;
    logic       frame_start;
    logic       sync_err;
    logic [9:0] line_period;
    logic [9:0] frame_lines;

    modport master (
        output hsync, vsync,
        input  h_cnt, v_cnt, valid, locked, frame_start, sync_err,
        input  line_period, frame_lines
    );

    modport slave (
        input  hsync, vsync,
        output h_cnt, v_cnt, valid, locked, frame_start, sync_err,
        output line_period, frame_lines
    );
endinterface

// File: rtl/vga_timing_rx.sv
`timescale 1ns/1ps
// VGA timing receiver: rebuilds pixel/line position from a pclk-synchronous
// hsync/vsync pair, measures line period and frame height against the
// nominal timing, and locks once enough consecutive frames check out.
module vga_timing_rx #(
    parameter int HD          = 640,
    parameter int HT          = 800,
    parameter int VD          = 480,
    parameter int VT          = 525,
    parameter int H_SYNC_PIX  = 656,
    parameter int V_SYNC_LINE = 489,
    parameter int LOCK_FRAMES = 2,
    parameter int SYNC_POL    = 0
) (
    input  logic           pclk,
    input  logic           reset,
    vga_timing_rx_if.slave vid
);

    localparam logic [9:0] HD_W        = 10'(HD);
    localparam logic [9:0] VD_W        = 10'(VD);
    localparam logic [9:0] HT_W        = 10'(HT);
    localparam logic [9:0] VT_W        = 10'(VT);
    localparam logic [9:0] X_LAST      = 10'(HT - 1);
    localparam logic [9:0] Y_LAST      = 10'(VT - 1);
    localparam logic [9:0] X_SYNC_NEXT = 10'(H_SYNC_PIX + 1);
    localparam logic [9:0] Y_SYNC_NEXT = 10'(V_SYNC_LINE + 1);
    localparam logic [9:0] CNT_MAX     = 10'h3FF;
    localparam logic [2:0] LOCK_W      = 3'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // Syncs normalised to active-low; delayed copies rest at the inactive level.
    logic       hs_n, vs_n;
    logic       hs_p1, vs_p1;
    logic       hs_edge, vs_edge;

    logic [9:0] x, y;
    logic       v_pend;
    logic       x_wrap;

    logic [9:0] per_cnt, ln_cnt;
    logic [9:0] line_period_q, frame_lines_q;

    logic       per_bad, ln_bad, mismatch;

    state_t     state_q, state_d;
    logic [2:0] good_q, good_d, good_inc;
    logic       err_d, sync_err_q;
    logic       locked_w;

    assign hs_n    = (SYNC_POL != 0) ? ~vid.hsync : vid.hsync;
    assign vs_n    = (SYNC_POL != 0) ? ~vid.vsync : vid.vsync;
    assign hs_edge = hs_p1 & ~hs_n;
    assign vs_edge = vs_p1 & ~vs_n;

    // Sync edge detector delay stage.
    always_ff @(posedge pclk) begin
        if (reset) begin
            hs_p1 <= 1'b1;
            vs_p1 <= 1'b1;
        end else begin
            hs_p1 <= hs_n;
            vs_p1 <= vs_n;
        end
    end

    // A hsync edge takes priority over the natural end-of-line wrap.
    assign x_wrap = !hs_edge && (x == X_LAST);

    // Position counters: x re-phased by hsync, y re-phased one line after vsync.
    always_ff @(posedge pclk) begin
        if (reset) begin
            x      <= '0;
            y      <= '0;
            v_pend <= 1'b0;
        end else begin
            if (hs_edge)
                x <= X_SYNC_NEXT;
            else if (x == X_LAST)
                x <= '0;
            else
                x <= x + 10'd1;

            if (x_wrap) begin
                // An edge seen on the wrap cycle still belongs to the line now ending.
                if (v_pend || vs_edge) begin
                    y      <= Y_SYNC_NEXT;
                    v_pend <= 1'b0;
                end else if (y == Y_LAST) begin
                    y <= '0;
                end else begin
                    y <= y + 10'd1;
                end
            end else if (vs_edge) begin
                v_pend <= 1'b1;
            end
        end
    end

    // Line period measurement: cycles between consecutive hsync edges.
    always_ff @(posedge pclk) begin
        if (reset) begin
            per_cnt       <= '0;
            line_period_q <= '0;
        end else if (hs_edge) begin
            per_cnt       <= 10'd1;
            line_period_q <= per_cnt;
        end else if (per_cnt != CNT_MAX) begin
            per_cnt <= per_cnt + 10'd1;
        end
    end

    // Frame height measurement: hsync edges between consecutive vsync edges.
    // A hsync edge coinciding with the vsync edge opens the new count.
    always_ff @(posedge pclk) begin
        if (reset) begin
            ln_cnt        <= '0;
            frame_lines_q <= '0;
        end else if (vs_edge) begin
            frame_lines_q <= ln_cnt;
            ln_cnt        <= hs_edge ? 10'd1 : 10'd0;
        end else if (hs_edge && (ln_cnt != CNT_MAX)) begin
            ln_cnt <= ln_cnt + 10'd1;
        end
    end

    // Overflow terms fire on the single cycle the counter steps to nominal+1.
    assign per_bad  = hs_edge ? (per_cnt != HT_W) : (per_cnt == HT_W);
    assign ln_bad   = vs_edge ? (ln_cnt != VT_W) : (hs_edge && (ln_cnt == VT_W));
    assign mismatch = per_bad | ln_bad;
    assign good_inc = good_q + 3'd1;

    // Lock FSM next state; a mismatch outranks a coincident vsync edge.
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        err_d   = 1'b0;
        case (state_q)
            SEARCH: begin
                good_d = '0;
                if (vs_edge)
                    state_d = VERIFY;
            end
            VERIFY: begin
                if (mismatch) begin
                    err_d   = 1'b1;
                    state_d = SEARCH;
                    good_d  = '0;
                end else if (vs_edge) begin
                    good_d = good_inc;
                    if (good_inc >= LOCK_W)
                        state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (mismatch) begin
                    err_d   = 1'b1;
                    state_d = SEARCH;
                    good_d  = '0;
                end
            end
            default: begin
                state_d = SEARCH;
                good_d  = '0;
            end
        endcase
    end

    // Lock FSM state and error pulse registers.
    always_ff @(posedge pclk) begin
        if (reset) begin
            state_q    <= SEARCH;
            good_q     <= '0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            good_q     <= good_d;
            sync_err_q <= err_d;
        end
    end

    assign locked_w = (state_q == LOCKED);

    assign vid.h_cnt       = (locked_w && (x < HD_W)) ? x : '0;
    assign vid.v_cnt       = (locked_w && (y < VD_W)) ? y : '0;
    assign vid.valid       = locked_w && (x < HD_W) && (y < VD_W);
    assign vid.locked      = locked_w;
    assign vid.frame_start = locked_w && (x == '0) && (y == '0);
    assign vid.sync_err    = sync_err_q;
    assign vid.line_period = line_period_q;
    assign vid.frame_lines = frame_lines_q;

endmodule

// File: tb/tb_vga_timing_rx.sv
`timescale 1ns/1ps
// Bench for vga_timing_rx on a scaled 30x16 raster. Two receivers, one per
// sync polarity, watch the same generator; each check covers both at once
// (values packed dut0 then dut1).
module tb_vga_timing_rx;

    localparam int HD = 20;
    localparam int HT = 30;
    localparam int HS = 22;
    localparam int VD = 12;
    localparam int VT = 16;
    localparam int VS = 13;
    localparam int F  = HT * VT;

    logic pclk = 1'b0;
    logic reset;

    always #5 pclk = ~pclk;

    vga_timing_rx_if if0 ();
    vga_timing_rx_if if1 ();

    vga_timing_rx #(
        .HD(HD), .HT(HT), .VD(VD), .VT(VT),
        .H_SYNC_PIX(HS), .V_SYNC_LINE(VS), .LOCK_FRAMES(2), .SYNC_POL(0)
    ) dut0 (
        .pclk(pclk), .reset(reset), .vid(if0)
    );

    vga_timing_rx #(
        .HD(HD), .HT(HT), .VD(VD), .VT(VT),
        .H_SYNC_PIX(HS), .V_SYNC_LINE(VS), .LOCK_FRAMES(2), .SYNC_POL(1)
    ) dut1 (
        .pclk(pclk), .reset(reset), .vid(if1)
    );

    int errors = 0;
    int checks = 0;
    int gx, gy, line_len, frame_len;
    bit kill;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        logic hs_act, vs_act;
        hs_act = !kill && (gx >= HS) && (gx < HS + 3);
        vs_act = ((gy == VS) && (gx >= HS)) || (gy == VS + 1) || ((gy == VS + 2) && (gx < HS));
        if0.hsync = ~hs_act;
        if0.vsync = ~vs_act;
        if1.hsync = hs_act;
        if1.vsync = vs_act;
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
        if (gx == line_len - 1) begin
            gx       = 0;
            line_len = HT;
            if (gy == frame_len - 1) begin
                gy        = 0;
                frame_len = VT;
            end else begin
                gy++;
            end
        end else begin
            gx++;
        end
        drive();
    endtask

    task automatic step_to(input int tx, input int ty);
        for (int n = 0; n < 4 * F; n++) begin
            step();
            if (gx == tx && (ty < 0 || gy == ty)) break;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " h_cnt"},       {if0.h_cnt, if1.h_cnt}, 32'd0);
        chk({tag, " v_cnt"},       {if0.v_cnt, if1.v_cnt}, 32'd0);
        chk({tag, " valid"},       {if0.valid, if1.valid}, 32'd0);
        chk({tag, " locked"},      {if0.locked, if1.locked}, 32'd0);
        chk({tag, " frame_start"}, {if0.frame_start, if1.frame_start}, 32'd0);
        chk({tag, " sync_err"},    {if0.sync_err, if1.sync_err}, 32'd0);
        chk({tag, " line_period"}, {if0.line_period, if1.line_period}, 32'd0);
        chk({tag, " frame_lines"}, {if0.frame_lines, if1.frame_lines}, 32'd0);
    endtask

    // Lock is expected one cycle after the 3rd vsync edge, not before.
    task automatic relock(input string tag);
        for (int k = 1; k <= 3; k++) begin
            step_to(HS, VS);
            chk({tag, " locked at edge"}, {if0.locked, if1.locked}, 32'd0);
            step();
            chk({tag, " locked after edge"}, {if0.locked, if1.locked}, (k == 3) ? 32'd3 : 32'd0);
        end
    endtask

    initial begin
        int fs_count;
        logic [9:0] eh, ev;
        logic ev_ok;

        reset     = 1'b1;
        gx        = 0;
        gy        = 0;
        line_len  = HT;
        frame_len = VT;
        kill      = 1'b0;
        drive();
        repeat (3) @(posedge pclk);
        #1;
        chk_zero("reset");
        reset = 1'b0;

        // First hsync edge after reset: period counted from zero, no spurious edge.
        step_to(HS, 0);
        step();
        chk("first period", {if0.line_period, if1.line_period}, {10'd22, 10'd22});
        chk("first no err", {if0.sync_err, if1.sync_err}, 32'd0);

        // Nominal lock and one full frame of position tracking.
        relock("lock");
        chk("nom period", {if0.line_period, if1.line_period}, {10'd30, 10'd30});
        chk("nom lines",  {if0.frame_lines, if1.frame_lines}, {10'd16, 10'd16});
        fs_count = 0;
        for (int i = 0; i < F; i++) begin
            ev_ok = (gx < HD) && (gy < VD);
            eh    = (gx < HD) ? 10'(gx) : 10'd0;
            ev    = (gy < VD) ? 10'(gy) : 10'd0;
            chk("trk h_cnt",  {if0.h_cnt, if1.h_cnt}, {eh, eh});
            chk("trk v_cnt",  {if0.v_cnt, if1.v_cnt}, {ev, ev});
            chk("trk valid",  {if0.valid, if1.valid}, {ev_ok, ev_ok});
            chk("trk locked", {if0.locked, if1.locked}, 32'd3);
            chk("trk err",    {if0.sync_err, if1.sync_err}, 32'd0);
            if (if0.frame_start) fs_count++;
            step();
        end
        chk("frame_start count", fs_count, 1);

        // One line shortened by a cycle.
        step_to(0, 5);
        line_len = HT - 1;
        step_to(HS, 6);
        chk("short pre locked", {if0.locked, if1.locked}, 32'd3);
        chk("short pre err",    {if0.sync_err, if1.sync_err}, 32'd0);
        step();
        chk("short period", {if0.line_period, if1.line_period}, {10'd29, 10'd29});
        chk("short err",    {if0.sync_err, if1.sync_err}, 32'd3);
        chk("short locked", {if0.locked, if1.locked}, 32'd0);
        step();
        chk("short err once", {if0.sync_err, if1.sync_err}, 32'd0);
        relock("relock short");

        // One frame shortened by a line.
        frame_len = VT - 1;
        step_to(HS, VS);
        chk("frame pre err", {if0.sync_err, if1.sync_err}, 32'd0);
        step();
        chk("frame lines",  {if0.frame_lines, if1.frame_lines}, {10'd15, 10'd15});
        chk("frame err",    {if0.sync_err, if1.sync_err}, 32'd3);
        chk("frame locked", {if0.locked, if1.locked}, 32'd0);
        step();
        chk("frame err once", {if0.sync_err, if1.sync_err}, 32'd0);
        relock("relock frame");

        // Reset pulse mid-frame while locked.
        step_to(5, 2);
        reset = 1'b1;
        step();
        chk_zero("midreset");
        reset = 1'b0;
        do begin
            step();
            chk("midreset no err", {if0.sync_err, if1.sync_err}, 32'd0);
        end while (gx != HS);
        step();
        chk("midreset period", {if0.line_period, if1.line_period}, {10'd16, 10'd16});
        chk("midreset lines",  {if0.frame_lines, if1.frame_lines}, 32'd0);
        chk("midreset locked", {if0.locked, if1.locked}, 32'd0);
        relock("relock reset");

        // hsync held inactive after an edge: overflow fires once at HT+1.
        step_to(HS, -1);
        kill = 1'b1;
        for (int i = 1; i <= HT; i++) begin
            step();
            chk("hold err quiet", {if0.sync_err, if1.sync_err}, 32'd0);
            chk("hold locked",    {if0.locked, if1.locked}, 32'd3);
        end
        step();
        chk("hold err",    {if0.sync_err, if1.sync_err}, 32'd3);
        chk("hold unlock", {if0.locked, if1.locked}, 32'd0);
        for (int i = 0; i < 100; i++) begin
            step();
            chk("hold err once", {if0.sync_err, if1.sync_err}, 32'd0);
        end
        repeat (1000) step();
        step_to(0, -1);
        kill = 1'b0;
        step_to(HS, -1);
        step();
        chk("period saturate", {if0.line_period, if1.line_period}, {10'd1023, 10'd1023});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
